// File: rtl/sme_job_scheduler_if.sv
// Host/engine bus of the job scheduler: string load, pattern queue,
// engine byte stream and tagged result handshake.
// slave = scheduler side, master = host plus engine side.
interface sme_job_scheduler_if #(
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned TAG_W = $clog2(QDEPTH);

    logic             str_wr;
    logic [7:0]       str_data;
    logic             str_last;
    logic             str_ready;
    logic             pat_wr;
    logic [7:0]       pat_data;
    logic             pat_last;
    logic             pat_full;
    logic [7:0]       eng_chardata;
    logic             eng_isstring;
    logic             eng_ispattern;
    logic             eng_valid;
    logic             eng_match;
    logic [4:0]       eng_match_index;
    logic             res_valid;
    logic             res_ready;
    logic             res_match;
    logic [4:0]       res_index;
    logic [TAG_W-1:0] res_tag;
    logic             res_timeout;
    logic             busy;

    modport slave (
        input  str_wr, str_data, str_last, pat_wr, pat_data, pat_last,
               eng_valid, eng_match, eng_match_index, res_ready,
        output str_ready, pat_full, eng_chardata, eng_isstring, eng_ispattern,
               res_valid, res_match, res_index, res_tag, res_timeout, busy
    );

    modport master (
        output str_wr, str_data, str_last, pat_wr, pat_data, pat_last,
               eng_valid, eng_match, eng_match_index, res_ready,
        input  str_ready, pat_full, eng_chardata, eng_isstring, eng_ispattern,
               res_valid, res_match, res_index, res_tag, res_timeout, busy
    );
endinterface

// File: rtl/sme_job_scheduler.sv
// Job scheduler in front of the string matching engine. Holds one target
// string and a queue of patterns, replays each job to the engine as a
// serial byte stream and returns tagged results with a watchdog timeout.
// Optional feature macro: SME_SCHED_STR_REUSE_EN (skip resending an
// unchanged string; engine keeps its copy on pattern-only jobs).
module sme_job_scheduler #(
    parameter int unsigned STR_MAX  = 32,
    parameter int unsigned PAT_MAX  = 8,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned WDOG_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    sme_job_scheduler_if.slave    bus
);
    localparam int unsigned SA_W = $clog2(STR_MAX);
    localparam int unsigned SL_W = $clog2(STR_MAX + 1);
    localparam int unsigned PA_W = $clog2(PAT_MAX);
    localparam int unsigned PL_W = $clog2(PAT_MAX + 1);
    localparam int unsigned QA_W = $clog2(QDEPTH);
    localparam int unsigned QC_W = QA_W + 1;
    localparam int unsigned WD_W = $clog2(WDOG_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_STR,
        S_SEND_PAT,
        S_WAIT
    } state_t;

    // String buffer and its control
    logic [7:0]      r_str [STR_MAX];
    logic [SL_W-1:0] r_str_len;
    logic            r_str_open;
    logic            r_str_loaded;
    logic            r_str_new;

    // Pattern queue
    logic [7:0]      r_pat     [QDEPTH][PAT_MAX];
    logic [PL_W-1:0] r_pat_len [QDEPTH];
    logic [QA_W-1:0] r_wptr;
    logic [QA_W-1:0] r_rptr;
    logic [QC_W-1:0] r_count;
    logic [PL_W-1:0] r_wlen;
    logic            r_pat_full;

    // Job sequencer
    state_t          r_state;
    logic [SL_W-1:0] r_k;
    logic [PL_W-1:0] r_job_plen;
    logic [QA_W-1:0] r_job_tag;
    logic [WD_W-1:0] r_wdog;

    // Registered outputs
    logic [7:0]      r_chardata;
    logic            r_isstring;
    logic            r_ispattern;
    logic            r_res_valid;
    logic            r_res_match;
    logic [4:0]      r_res_index;
    logic [QA_W-1:0] r_res_tag;
    logic            r_res_timeout;
    logic            r_busy;
    logic            r_str_ready;

    logic            w_str_acc;
    logic            w_str_room;
    logic            w_str_we;
    logic [SA_W-1:0] w_str_widx;
    logic            w_pat_acc;
    logic            w_pat_room;
    logic            w_pat_we;
    logic            w_commit;
    logic [PL_W-1:0] w_commit_len;
    logic            w_pop;
    logic            w_str_end;
    logic            w_skip_str;
    logic            w_launch;
    logic [QC_W-1:0] w_count_nxt;

    assign w_str_acc    = bus.str_wr & r_str_ready;
    assign w_str_room   = (r_str_len < SL_W'(STR_MAX));
    assign w_str_we     = w_str_acc & (~r_str_open | w_str_room);
    assign w_str_widx   = r_str_open ? r_str_len[SA_W-1:0] : '0;

    assign w_pat_acc    = bus.pat_wr & ~r_pat_full;
    assign w_pat_room   = (r_wlen < PL_W'(PAT_MAX));
    assign w_pat_we     = w_pat_acc & w_pat_room;
    assign w_commit     = w_pat_acc & bus.pat_last;
    assign w_commit_len = w_pat_room ? r_wlen + PL_W'(1) : r_wlen;

    assign w_str_end    = (r_k == r_str_len - SL_W'(1));
    assign w_pop        = (r_state == S_SEND_PAT) &&
                          (r_k == SL_W'(r_job_plen) - SL_W'(1));
    assign w_count_nxt  = r_count + QC_W'(w_commit) - QC_W'(w_pop);

`ifdef SME_SCHED_STR_REUSE_EN
    assign w_skip_str = ~r_str_new;
`else
    assign w_skip_str = 1'b0;
`endif

    // A string byte arriving in the launch cycle would overwrite the buffer
    // about to be replayed, so it holds the launch off as well.
    assign w_launch = (r_state == S_IDLE) && (r_count != '0) &&
                      r_str_loaded && ~r_str_open && ~w_str_acc &&
                      (~r_res_valid | bus.res_ready);

    // Byte storage for the string and the pattern write entry
    always_ff @(posedge clk) begin
        if (w_str_we) begin
            r_str[w_str_widx] <= bus.str_data;
        end
        if (w_pat_we) begin
            r_pat[r_wptr][r_wlen[PA_W-1:0]] <= bus.pat_data;
        end
        if (w_commit) begin
            r_pat_len[r_wptr] <= w_commit_len;
        end
    end

    // Queue pointers, occupancy and full flag (commit and pop may coincide).
    // The write pointer doubles as the tag counter: tags are assigned in
    // commit order modulo QDEPTH, so an entry's tag equals its slot index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_wlen     <= '0;
            r_pat_full <= 1'b0;
        end else begin
            if (w_pat_we) begin
                r_wlen <= r_wlen + PL_W'(1);
            end
            if (w_commit) begin
                r_wptr <= r_wptr + QA_W'(1);
                r_wlen <= '0;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + QA_W'(1);
            end
            r_count    <= w_count_nxt;
            r_pat_full <= (w_count_nxt == QC_W'(QDEPTH));
        end
    end

    // Job FSM with string load control, engine drive and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_job_plen    <= '0;
            r_job_tag     <= '0;
            r_wdog        <= '0;
            r_str_len     <= '0;
            r_str_open    <= 1'b0;
            r_str_loaded  <= 1'b0;
            r_str_new     <= 1'b0;
            r_chardata    <= '0;
            r_isstring    <= 1'b0;
            r_ispattern   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_match   <= 1'b0;
            r_res_index   <= '0;
            r_res_tag     <= '0;
            r_res_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_str_ready   <= 1'b1;
        end else begin
            r_isstring  <= 1'b0;
            r_ispattern <= 1'b0;

            if (r_res_valid && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end

            if (w_str_acc) begin
                if (!r_str_open) begin
                    r_str_len <= SL_W'(1);
                end else if (w_str_room) begin
                    r_str_len <= r_str_len + SL_W'(1);
                end
                r_str_open <= ~bus.str_last;
                if (bus.str_last) begin
                    r_str_loaded <= 1'b1;
                    r_str_new    <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_job_plen  <= r_pat_len[r_rptr];
                        r_job_tag   <= r_rptr;
                        r_k         <= '0;
                        r_busy      <= 1'b1;
                        r_str_ready <= 1'b0;
                        r_state     <= w_skip_str ? S_SEND_PAT : S_SEND_STR;
                    end
                end
                S_SEND_STR: begin
                    r_isstring <= 1'b1;
                    r_chardata <= r_str[r_k[SA_W-1:0]];
                    r_str_new  <= 1'b0;
                    if (w_str_end) begin
                        r_k     <= '0;
                        r_state <= S_SEND_PAT;
                    end else begin
                        r_k <= r_k + SL_W'(1);
                    end
                end
                S_SEND_PAT: begin
                    r_ispattern <= 1'b1;
                    r_chardata  <= r_pat[r_rptr][r_k[PA_W-1:0]];
                    if (w_pop) begin
                        r_k     <= '0;
                        r_wdog  <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_k <= r_k + SL_W'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.eng_valid) begin
                        r_res_valid   <= 1'b1;
                        r_res_match   <= bus.eng_match;
                        r_res_index   <= bus.eng_match_index;
                        r_res_tag     <= r_job_tag;
                        r_res_timeout <= 1'b0;
                        r_busy        <= 1'b0;
                        r_str_ready   <= 1'b1;
                        r_state       <= S_IDLE;
                    end else if (r_wdog == WD_W'(WDOG_CYC - 1)) begin
                        r_res_valid   <= 1'b1;
                        r_res_match   <= 1'b0;
                        r_res_index   <= '0;
                        r_res_tag     <= r_job_tag;
                        r_res_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_str_ready   <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.str_ready     = r_str_ready;
    assign bus.pat_full      = r_pat_full;
    assign bus.eng_chardata  = r_chardata;
    assign bus.eng_isstring  = r_isstring;
    assign bus.eng_ispattern = r_ispattern;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_match     = r_res_match;
    assign bus.res_index     = r_res_index;
    assign bus.res_tag       = r_res_tag;
    assign bus.res_timeout   = r_res_timeout;
    assign bus.busy          = r_busy;
endmodule

// File: doc/sme_job_scheduler.md
# sme_job_scheduler

Job scheduler that sits in front of the string matching engine. The host loads one target string and queues up to QDEPTH patterns. The block replays each job into the engine's serial `isstring`/`ispattern` byte interface, waits for the engine's `valid` pulse, and returns each match result tagged with its job id. It serialises all engine access, so the engine sees exactly one job at a time and never sees host back-pressure.

## Interface
- STR_MAX, 32: string buffer depth in bytes; length counter is 6 bits.
- PAT_MAX, 8: maximum pattern length in bytes.
- QDEPTH, 4: pattern queue entries (power of 2).
- WDOG_CYC, 255: cycles waited for engine `valid` before a timeout result is produced.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- str_wr  in  1  string byte strobe.
- str_data  in  8  string byte.
- str_last  in  1  marks the final string byte, qualified by str_wr.
- str_ready  out  1  high only in IDLE; str_wr is ignored when low.
- pat_wr  in  1  pattern byte strobe.
- pat_data  in  8  pattern byte.
- pat_last  in  1  marks the final pattern byte; commits the queue entry.
- pat_full  out  1  queue holds QDEPTH committed entries.
- eng_chardata  out  8  byte to the engine.
- eng_isstring  out  1  string byte valid to the engine.
- eng_ispattern  out  1  pattern byte valid to the engine.
- eng_valid  in  1  engine result pulse.
- eng_match  in  1  engine match flag.
- eng_match_index  in  5  engine match index.
- res_valid  out  1  result register holds an unread result.
- res_ready  in  1  host accepts the result.
- res_match  out  1  result match flag.
- res_index  out  5  result match index.
- res_tag  out  log2(QDEPTH)  job id, assigned at commit, wraps modulo QDEPTH.
- res_timeout  out  1  the watchdog expired for this job.
- busy  out  1  state is not IDLE.

## Operation
- **String load**
  - The first accepted str_wr after reset or after a str_last writes index 0.
  - Length saturates at STR_MAX; excess bytes are dropped.
  - str_last sets str_loaded and str_new. While a string is partially written (str_open), no job launches.
- **Pattern queue**
  - Bytes accumulate into the write entry. Bytes beyond PAT_MAX are dropped; length saturates.
  - pat_last commits the entry together with the current tag counter, then increments the counter.
  - pat_wr while pat_full is dropped in full, including any pat_last.
- **State machine** IDLE → SEND_STR → SEND_PAT → WAIT → IDLE.
  - IDLE launches when queue is non-empty, str_loaded=1, str_open=0, and (res_valid=0 or res_ready=1).
  - Launch goes to SEND_STR, or directly to SEND_PAT when string reuse applies (see Configuration).
  - SEND_STR drives str_len cycles: eng_isstring=1, eng_chardata=str[k]. It clears str_new.
  - SEND_PAT drives pat_len cycles: eng_ispattern=1, eng_chardata=pat[k]. It follows SEND_STR with no gap. It pops the queue entry on its last byte.
  - WAIT drives eng_isstring=0, eng_ispattern=0 and counts cycles.
  - In WAIT, eng_valid=1 loads res_match, res_index and the entry's tag; sets res_valid=1, res_timeout=0; returns to IDLE.
  - If the WAIT count reaches WDOG_CYC, the result is loaded with res_match=0, res_index=0, res_timeout=1.
- **Result handshake:** res_valid clears on res_valid&res_ready unless a new result loads in the same cycle.
- **Ignored inputs:** eng_valid outside WAIT is ignored. pat_wr is accepted in every state; str_wr only in IDLE.

## Timing
- All outputs are registered.
- Reset values: every output 0 except str_ready=1. Queue empty, tag counter 0, str_loaded=0, str_new=0, state IDLE.
- Launch latency: launch conditions true at edge t puts the first engine byte on outputs after edge t+1.
- A job occupies 1 + str_len + pat_len engine-drive cycles, plus the engine compute time.
- res_valid rises on the edge after eng_valid is sampled high.
- Pattern commit and pop in the same cycle: occupancy is unchanged, and pat_full stays correct.
- A commit arriving while the queue was empty may launch at the earliest on the next edge.
- Reset mid-job returns to IDLE on the next edge and drops the in-flight job, the queue and the string. The engine shares the reset.

## Configuration
- SME_SCHED_STR_REUSE_EN defined:
  - A launch with str_new=0 skips SEND_STR and sends only the pattern.
  - The engine retains the string on a pattern-only sequence.
- SME_SCHED_STR_REUSE_EN undefined: every job sends the full string before its pattern.

## Test plan
- **Basic match:** load "hello world", queue "wor" → engine sees 11 isstring cycles then 3 ispattern cycles. Result: res_match=1, res_index=6, res_tag=0.
- **Queue full:** queue 4 patterns without reading results → pat_full=1. A 5th pattern is dropped. Results return in order with tags 0,1,2,3. No launch occurs while res_valid=1 and res_ready=0.
- **String reuse:** two jobs against one string with SME_SCHED_STR_REUSE_EN → the second job has 0 isstring cycles. Without the macro, both jobs send 11 string cycles.
- **Watchdog:** engine model never pulses valid → res_timeout=1, res_match=0 after WDOG_CYC=255 WAIT cycles. A late eng_valid is ignored.
- **Overlength inputs:** a 40-byte string and a 10-byte pattern → exactly 32 and 8 bytes are sent to the engine.
- **Reset mid-job:** reset during SEND_PAT → next cycle busy=0, eng_ispattern=0, pat_full=0, res_valid=0. No result is produced.
